div_unit: RTL

//  Iterative RV32M/RV64M divider (DIV/DIVU/REM/REMU) beside the x0/x1/x2 multiplier chain.

---
 rtl/div_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring RV32M/RV64M divider (DIV/DIVU/REM/REMU)
module div_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] OP1_SE,
    input  logic [XLEN-1:0] OP2_SE,
    input  logic [1:0]      DIV_CMD_RD,
    input  logic [5:0]      DEST_RD,
    input  logic            DEC2DIV_EMPTY_SD,
    output logic            DEC2DIV_POP_SDV,
    input  logic            EXCEPTION_SM,
    output logic [XLEN-1:0] RES_RDV,
    output logic [5:0]      DEST_RDV,
    output logic            DIV2WBK_EMPTY_SDV,
    input  logic            DIV2WBK_POP_SW,
    output logic            DIV_BUSY_SDV
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]      cmd_r;
    logic [5:0]      tag_r;
    logic [XLEN-1:0] dvd_r;
    logic [XLEN-1:0] dvs_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN:0]   rem_r;
    logic [CW-1:0]   cnt_r;
    logic            q_neg_r;
    logic            r_neg_r;
    logic [XLEN-1:0] res_r;
    logic [5:0]      dest_r;

    logic            pop;
    logic            signed_op;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_res;

    logic [XLEN:0]   rem_v;
    logic [XLEN-1:0] dvd_v;
    logic [XLEN-1:0] quo_v;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] res_calc;
    logic            last_calc;

    assign pop       = (state == S_IDLE) & ~DEC2DIV_EMPTY_SD & ~EXCEPTION_SM;
    assign signed_op = ~DIV_CMD_RD[0];
    assign sign1     = signed_op & OP1_SE[XLEN-1];
    assign sign2     = signed_op & OP2_SE[XLEN-1];
    assign abs1      = sign1 ? (~OP1_SE + 1'b1) : OP1_SE;
    assign abs2      = sign2 ? (~OP2_SE + 1'b1) : OP2_SE;
    assign div_zero  = (OP2_SE == '0);
    assign ovf       = signed_op & (OP1_SE == {1'b1, {(XLEN-1){1'b0}}}) & (OP2_SE == '1);
    assign special   = div_zero | ovf;

    // Divide-by-zero takes precedence: -2^(XLEN-1)/0 is a zero-divisor case, not overflow.
    always_comb begin
        spec_res = '0;
        if (div_zero) begin
            spec_res = DIV_CMD_RD[1] ? OP1_SE : '1;
        end else begin
            spec_res = DIV_CMD_RD[1] ? '0 : OP1_SE;
        end
    end

    // BITS_PER_CYCLE chained restoring steps; remainder stays XLEN+1 bits wide.
    always_comb begin
        rem_v = rem_r;
        dvd_v = dvd_r;
        quo_v = quo_r;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_v = {rem_v[XLEN-1:0], dvd_v[XLEN-1]};
            dvd_v = {dvd_v[XLEN-2:0], 1'b0};
            if (rem_v >= {1'b0, dvs_r}) begin
                rem_v = rem_v - {1'b0, dvs_r};
                quo_v = {quo_v[XLEN-2:0], 1'b1};
            end else begin
                quo_v = {quo_v[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        quo_fix  = q_neg_r ? (~quo_v + 1'b1) : quo_v;
        rem_fix  = r_neg_r ? (~rem_v[XLEN-1:0] + 1'b1) : rem_v[XLEN-1:0];
        res_calc = cmd_r[1] ? rem_fix : quo_fix;
    end

    assign last_calc = (state == S_CALC) && (cnt_r == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_r == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (DIV2WBK_POP_SW) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (EXCEPTION_SM) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_r   <= '0;
            tag_r   <= '0;
            dvd_r   <= '0;
            dvs_r   <= '0;
            quo_r   <= '0;
            rem_r   <= '0;
            cnt_r   <= '0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            res_r   <= '0;
            dest_r  <= '0;
        end else begin
            if (pop) begin
                cmd_r   <= DIV_CMD_RD;
                tag_r   <= DEST_RD;
                dvd_r   <= abs1;
                dvs_r   <= abs2;
                quo_r   <= '0;
                rem_r   <= '0;
                cnt_r   <= CW'(N - 1);
                q_neg_r <= sign1 ^ sign2;
                r_neg_r <= sign1;
                if (special) begin
                    res_r  <= spec_res;
                    dest_r <= DEST_RD;
                end
            end
            // A flush freezes the datapath so RES_RDV keeps the last delivered value.
            if ((state == S_CALC) && !EXCEPTION_SM) begin
                rem_r <= rem_v;
                dvd_r <= dvd_v;
                quo_r <= quo_v;
                cnt_r <= cnt_r - 1'b1;
                if (last_calc) begin
                    res_r  <= res_calc;
                    dest_r <= tag_r;
                end
            end
        end
    end

    assign DEC2DIV_POP_SDV   = pop;
    assign RES_RDV           = res_r;
    assign DEST_RDV          = dest_r;
    assign DIV2WBK_EMPTY_SDV = (state != S_DONE);
    assign DIV_BUSY_SDV      = (state != S_IDLE);

endmodule
